// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   arbState_t      : FSM state encoding (2'b11 is illegal and recovers to IDLE)
//   HOLD_CNT_W      : width of the grant-hold watchdog counter (MAX_HOLD up to 65535)
//   ownerWidth()    : width of an owner index for a given number of masters
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANTED = 2'b01,
    RELEASE = 2'b10
  } arbState_t;

  localparam int HOLD_CNT_W = 16;

  function automatic int ownerWidth(input int nMasters);
    return (nMasters > 1) ? $clog2(nMasters) : 1;
  endfunction

  localparam int OWNER_W_DEFAULT = ownerWidth(4);

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the core-side arbitration submodules and one
// bus arbiter (one instance for the I-bus, one for the D-bus).
//   Bus_RQ        : per-core level request
//   Bus_Mem_Ready : memory ready seen on the shared bus
//   Bus_GRANT     : one-hot or zero grant
//   Grant_Owner   : index of the current/last owner
//   Bus_Busy      : arbiter not idle
//   Hold_Timeout  : one-cycle pulse when the watchdog revokes a grant
// modport master : requester side; modport slave : arbiter side.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4
);
  localparam int W = ownerWidth(N_MASTERS);

  logic [N_MASTERS-1:0] Bus_RQ;
  logic                 Bus_Mem_Ready;
  logic [N_MASTERS-1:0] Bus_GRANT;
  logic [W-1:0]         Grant_Owner;
  logic                 Bus_Busy;
  logic                 Hold_Timeout;

  modport master (
    output Bus_RQ, Bus_Mem_Ready,
    input  Bus_GRANT, Grant_Owner, Bus_Busy, Hold_Timeout
  );

  modport slave (
    input  Bus_RQ, Bus_Mem_Ready,
    output Bus_GRANT, Grant_Owner, Bus_Busy, Hold_Timeout
  );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin winner selection.
//   req       : request vector
//   lastOwner : index of the previous owner; search starts one above it
//   winner    : first requesting index found searching upward with wrap
//   anyReq    : at least one request present
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  localparam int W = ownerWidth(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [W-1:0]         lastOwner,
  output logic [W-1:0]         winner,
  output logic                 anyReq
);

  // One spare bit so lastOwner + i cannot overflow before the wrap subtract.
  logic [W:0] idx;
  logic       found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = {1'b0, lastOwner} + (W+1)'(i);
      if (idx >= (W+1)'(N_MASTERS)) idx = idx - (W+1)'(N_MASTERS);
      if (!found && req[idx[W-1:0]]) begin
        winner = idx[W-1:0];
        found  = 1'b1;
      end
    end
  end

  assign anyReq = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with optional grant-hold watchdog.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : bus_arbiter_if.slave (requests, memory ready, grant outputs)
// Parameters: N_MASTERS (2..16), MAX_HOLD (0 disables the watchdog).
//
// state   | meaning
// IDLE    | no grant; next edge grants the round-robin winner if any request
// GRANTED | one core owns the bus; others ignored until it drops or times out
// RELEASE | grant dropped; wait for the memory side to deassert Ready
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int MAX_HOLD  = 0
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.slave  bus
);

  localparam int W = ownerWidth(N_MASTERS);
  localparam logic [HOLD_CNT_W-1:0] HoldLimit = HOLD_CNT_W'(MAX_HOLD - 1);

  arbState_t              state, stateNext;
  logic [N_MASTERS-1:0]   grantQ, grantNext;
  logic [W-1:0]           ownerQ, ownerNext;
  logic [W-1:0]           lastOwnerQ, lastOwnerNext;
  logic [HOLD_CNT_W-1:0]  holdCnt, holdCntNext;
  logic                   timeoutQ, timeoutNext;
  logic                   busyQ, busyNext;
  logic [W-1:0]           winner;
  logic                   anyReq;

  rr_picker #(.N_MASTERS(N_MASTERS)) uPicker (
    .req       (bus.Bus_RQ),
    .lastOwner (lastOwnerQ),
    .winner    (winner),
    .anyReq    (anyReq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grantQ     <= '0;
      ownerQ     <= '0;
      lastOwnerQ <= W'(N_MASTERS - 1);
      holdCnt    <= '0;
      timeoutQ   <= 1'b0;
      busyQ      <= 1'b0;
    end else begin
      state      <= stateNext;
      grantQ     <= grantNext;
      ownerQ     <= ownerNext;
      lastOwnerQ <= lastOwnerNext;
      holdCnt    <= holdCntNext;
      timeoutQ   <= timeoutNext;
      busyQ      <= busyNext;
    end
  end

  always_comb begin
    stateNext     = state;
    grantNext     = grantQ;
    ownerNext     = ownerQ;
    lastOwnerNext = lastOwnerQ;
    holdCntNext   = holdCnt;
    timeoutNext   = 1'b0;
    case (state)
      IDLE: begin
        grantNext = '0;
        if (anyReq) begin
          grantNext     = N_MASTERS'(1) << winner;
          ownerNext     = winner;
          lastOwnerNext = winner;
          holdCntNext   = '0;
          stateNext     = GRANTED;
        end
      end
      GRANTED: begin
        if (!bus.Bus_RQ[ownerQ]) begin
          grantNext = '0;
          stateNext = RELEASE;
        end else if (MAX_HOLD != 0 && holdCnt == HoldLimit) begin
          grantNext   = '0;
          timeoutNext = 1'b1;
          stateNext   = RELEASE;
        end else if (holdCnt != '1) begin
          holdCntNext = holdCnt + 1'b1;
        end
      end
      RELEASE: begin
        grantNext = '0;
        if (!bus.Bus_Mem_Ready) stateNext = IDLE;
      end
      default: begin
        // Illegal encoding: recover to IDLE with outputs cleared.
        stateNext   = IDLE;
        grantNext   = '0;
        ownerNext   = '0;
        holdCntNext = '0;
      end
    endcase
    busyNext = (stateNext != IDLE);
  end

  assign bus.Bus_GRANT    = grantQ;
  assign bus.Grant_Owner  = ownerQ;
  assign bus.Bus_Busy     = busyQ;
  assign bus.Hold_Timeout = timeoutQ;

endmodule
